// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between the fetch (IF) and data (MEM) stages.
// Optional `MEMARB_PERF_EN adds a saturating 32-bit perf_conflicts counter output.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned MAX_DATA_BURST = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_valid,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                dm_valid,
    output logic                stall_if,
    output logic                stall_mem,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
`ifdef MEMARB_PERF_EN
    output logic [31:0]         perf_conflicts,
`endif
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned BE_W    = DATA_W / 8;
    localparam int unsigned BURST_W = 4;
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_DATA_BURST);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_BUSY_I = 3'd1;
    localparam logic [2:0] S_BUSY_D = 3'd2;
    localparam logic [2:0] S_RESP_I = 3'd3;
    localparam logic [2:0] S_RESP_D = 3'd4;

    logic [2:0]         state_q,     state_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic               mem_req_q,   mem_req_d;
    logic               mem_we_q,    mem_we_d;
    logic [BE_W-1:0]    mem_be_q,    mem_be_d;
    logic [ADDR_W-1:0]  mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]  if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]  dm_rdata_q,  dm_rdata_d;
    logic               if_valid_q,  if_valid_d;
    logic               dm_valid_q,  dm_valid_d;
    logic               data_blocked_c;

    // Data loses IDLE arbitration only once it has used up its burst allowance.
    assign data_blocked_c = (burst_cnt_q == BURST_MAX) && if_req;

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (dm_req && !data_blocked_c) begin
                    state_d     = S_BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_be_d    = dm_be;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    if (burst_cnt_q != BURST_MAX) begin
                        burst_cnt_d = burst_cnt_q + BURST_W'(1);
                    end
                end else if (if_req) begin
                    state_d     = S_BUSY_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '1;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    burst_cnt_d = '0;
                end
            end
            S_BUSY_I: begin
                if (mem_ready) begin
                    state_d    = S_RESP_I;
                    mem_req_d  = 1'b0;
                    if_rdata_d = mem_rdata;
                    if_valid_d = 1'b1;
                end
            end
            S_BUSY_D: begin
                if (mem_ready) begin
                    state_d    = S_RESP_D;
                    mem_req_d  = 1'b0;
                    dm_valid_d = 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_d = mem_rdata;
                    end
                end
            end
            S_RESP_I, S_RESP_D: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            burst_cnt_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;

    // Stalls feed the hazard unit combinationally so it reacts in the request cycle.
    assign stall_if  = if_req & ~if_valid_q;
    assign stall_mem = dm_req & ~dm_valid_q;

`ifdef MEMARB_PERF_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;
    logic        conflict_c;

    assign conflict_c = if_req && dm_req && (stall_if || stall_mem);

    always_comb begin
        perf_cnt_d = perf_cnt_q;
        if (conflict_c && (perf_cnt_q != 32'hFFFF_FFFF)) begin
            perf_cnt_d = perf_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_cnt_q <= '0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
        end
    end

    assign perf_conflicts = perf_cnt_q;
`endif

endmodule
